// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap sequencer.
// Takes ecall/ebreak/mret and the machine timer interrupt. Writes mepc, mstatus
// and mcause (or mstatus alone for mret) one register per cycle through the CSR
// file's second write port, stalls the pipeline meanwhile, then redirects once.
// Optional build macro: CSR_TRAP_VECTORED_EN (vectored interrupt targets when
// mtvec mode == 2'b01).
module csr_trap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_ecall_i,
  input  logic        inst_ebreak_i,
  input  logic        inst_mret_i,
  input  logic        irq_timer_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, JUMP
  } state_t;

  localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBRK   = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  state_t      state_q;
  logic [31:0] pc_q, cause_q, target_q;

  logic        take_exc, take_mret, take_irq, accept;
  logic [31:0] mstatus_trap, mstatus_mret, trap_base, trap_vec;
  logic        unused_bits;

  // Event decode; priority ecall > ebreak > mret > interrupt is resolved in the FSM.
  always_comb begin
    take_exc  = inst_valid_i & (inst_ecall_i | inst_ebreak_i);
    take_mret = inst_valid_i & inst_mret_i;
    take_irq  = inst_valid_i & irq_timer_i & mstatus_i[3] & mie_i[7];
    accept    = take_exc | take_mret | take_irq;
  end

  // mstatus images built from the live value so an execute-stage write in the
  // acceptance cycle is preserved.
  always_comb begin
    mstatus_trap = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
    mstatus_mret = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
    trap_base    = {mtvec_i[31:2], 2'b00};
  end

`ifdef CSR_TRAP_VECTORED_EN
  // Vectored mode: interrupts land at base + 4*cause code; exceptions use base.
  always_comb begin
    if (cause_q[31] && (mtvec_i[1:0] == 2'b01))
      trap_vec = trap_base + {cause_q[29:0], 2'b00};
    else
      trap_vec = trap_base;
  end
  assign unused_bits = ^{mie_i[31:8], mie_i[6:0], cause_q[30]};
`else
  // Direct mode only: mode bits of mtvec are ignored.
  always_comb begin
    trap_vec = trap_base;
  end
  assign unused_bits = ^{mie_i[31:8], mie_i[6:0], mtvec_i[1:0]};
`endif

  // Sequencer: latch pc/cause on acceptance, walk the write states, then jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_exc) begin
            pc_q    <= inst_addr_i;
            cause_q <= inst_ecall_i ? CAUSE_ECALL : CAUSE_EBRK;
            state_q <= W_MEPC;
          end else if (take_mret) begin
            state_q <= W_MRET;
          end else if (take_irq) begin
            pc_q    <= inst_addr_i;
            cause_q <= CAUSE_TIMER;
            state_q <= W_MEPC;
          end
        end
        W_MEPC:    state_q <= W_MSTATUS;
        W_MSTATUS: state_q <= W_MCAUSE;
        W_MCAUSE: begin
          target_q <= trap_vec;
          state_q  <= JUMP;
        end
        W_MRET: begin
          target_q <= mepc_i;
          state_q  <= JUMP;
        end
        JUMP:      state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Output decode from state and latches; stall in IDLE follows the acceptance
  // condition so the accepting instruction is held in the same cycle.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    stall_o     = 1'b1;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    case (state_q)
      IDLE:      stall_o = accept & rst_n;
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = pc_q;
      end
      W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_trap;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      W_MRET: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_mret;
      end
      JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = target_q;
      end
      default:   stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: table-driven and randomized checks of csr_trap_ctrl
// against a per-event behavioural model of the trap/mret sequences.
module tb_csr_trap_ctrl;

`ifdef CSR_TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid_i, inst_ecall_i, inst_ebreak_i, inst_mret_i, irq_timer_i;
  logic [31:0] inst_addr_i, mtvec_i, mepc_i, mstatus_i, mie_i;
  logic        csr_we_o, stall_o, jump_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, jump_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  csr_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .inst_ecall_i(inst_ecall_i), .inst_ebreak_i(inst_ebreak_i),
    .inst_mret_i(inst_mret_i), .irq_timer_i(irq_timer_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
  } outv_t;

  // kind: 0 = nothing taken, 1 = trap, 2 = mret
  typedef struct {
    logic        valid, ecall, ebreak, mret, irq;
    logic [31:0] pc, mtvec, mepc, mstatus, mie;
    int          kind;
    logic [31:0] cause, mst_w, target;
  } rec_t;

  function automatic rec_t mk(logic v, logic ec, logic eb, logic mr, logic iq,
                              logic [31:0] pc, logic [31:0] mtvec, logic [31:0] mepc,
                              logic [31:0] mst, logic [31:0] mie, int kind,
                              logic [31:0] cause, logic [31:0] mstw, logic [31:0] tgt);
    rec_t r;
    r.valid = v; r.ecall = ec; r.ebreak = eb; r.mret = mr; r.irq = iq;
    r.pc = pc; r.mtvec = mtvec; r.mepc = mepc; r.mstatus = mst; r.mie = mie;
    r.kind = kind; r.cause = cause; r.mst_w = mstw; r.target = tgt;
    return r;
  endfunction

  // Reference model: decide the event from the architectural rules.
  function automatic rec_t predict(rec_t r);
    rec_t e;
    logic [31:0] base;
    e = r;
    e.kind = 0; e.cause = 0; e.mst_w = 0; e.target = 0;
    if (r.valid) begin
      if (r.ecall)       begin e.kind = 1; e.cause = 11; end
      else if (r.ebreak) begin e.kind = 1; e.cause = 3; end
      else if (r.mret)   e.kind = 2;
      else if (r.irq && r.mstatus[3] && r.mie[7]) begin
        e.kind = 1; e.cause = 32'h8000_0007;
      end
    end
    if (e.kind == 1) begin
      e.mst_w = r.mstatus;
      e.mst_w[7] = r.mstatus[3];
      e.mst_w[3] = 1'b0;
      base = r.mtvec & ~32'h3;
      e.target = base;
      if (VEC && e.cause[31] && (r.mtvec % 4 == 1))
        e.target = base + 4 * (e.cause & 32'h7fff_ffff);
    end else if (e.kind == 2) begin
      e.mst_w = r.mstatus;
      e.mst_w[3] = r.mstatus[7];
      e.mst_w[7] = 1'b1;
      e.target = r.mepc;
    end
    return e;
  endfunction

  // Expected outputs per cycle, starting with the acceptance cycle.
  function automatic void expand(rec_t r, output outv_t q[$]);
    q = {};
    q.push_back('{we:1'b0, waddr:32'h0, wdata:32'h0, stall:(r.kind != 0), jump:1'b0, jaddr:32'h0});
    if (r.kind == 1) begin
      q.push_back('{we:1'b1, waddr:32'h341, wdata:r.pc,    stall:1'b1, jump:1'b0, jaddr:32'h0});
      q.push_back('{we:1'b1, waddr:32'h300, wdata:r.mst_w, stall:1'b1, jump:1'b0, jaddr:32'h0});
      q.push_back('{we:1'b1, waddr:32'h342, wdata:r.cause, stall:1'b1, jump:1'b0, jaddr:32'h0});
      q.push_back('{we:1'b0, waddr:32'h0,   wdata:32'h0,   stall:1'b1, jump:1'b1, jaddr:r.target});
    end else if (r.kind == 2) begin
      q.push_back('{we:1'b1, waddr:32'h300, wdata:r.mst_w, stall:1'b1, jump:1'b0, jaddr:32'h0});
      q.push_back('{we:1'b0, waddr:32'h0,   wdata:32'h0,   stall:1'b1, jump:1'b1, jaddr:r.target});
    end
  endfunction

  task automatic chk(input string nm, input int cyc, input outv_t exp);
    outv_t act;
    act = {csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, jump_o, jump_addr_o};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc%0d: got we=%0b waddr=%h wdata=%h stall=%0b jump=%0b jaddr=%h, want we=%0b waddr=%h wdata=%h stall=%0b jump=%0b jaddr=%h",
               nm, cyc, act.we, act.waddr, act.wdata, act.stall, act.jump, act.jaddr,
               exp.we, exp.waddr, exp.wdata, exp.stall, exp.jump, exp.jaddr);
    end
  endtask

  // Apply one event in the next cycle and check every cycle of its sequence.
  task automatic do_event(input rec_t r, input string nm);
    outv_t q[$];
    expand(r, q);
    @(negedge clk);
    inst_valid_i = r.valid; inst_ecall_i = r.ecall; inst_ebreak_i = r.ebreak;
    inst_mret_i = r.mret;   irq_timer_i = r.irq;    inst_addr_i = r.pc;
    mtvec_i = r.mtvec; mepc_i = r.mepc; mstatus_i = r.mstatus; mie_i = r.mie;
    #1 chk(nm, 0, q[0]);
    for (int i = 1; i < q.size(); i++) begin
      @(negedge clk);
      inst_valid_i = 1'b0; inst_ecall_i = 1'b0; inst_ebreak_i = 1'b0; inst_mret_i = 1'b0;
      #1 chk(nm, i, q[i]);
    end
  endtask

  task automatic idle_check(input string nm);
    rec_t r;
    r = mk(0, 0, 0, 0, 0, inst_addr_i, mtvec_i, mepc_i, mstatus_i, mie_i, 0, 0, 0, 0);
    do_event(r, nm);
  endtask

  rec_t  tbl[12];
  rec_t  r, e;
  outv_t zero_v;
  logic [31:0] irq_tgt;

  initial begin
    irq_tgt = VEC ? 32'h21C : 32'h200;
    //            v ec eb mr iq  pc            mtvec         mepc          mstatus       mie           k  cause          mst_w          target
    tbl[0]  = mk(1, 1, 0, 0, 0, 32'h100,      32'h200,      32'h0,        32'h8,        32'h0,        1, 32'd11,        32'h80,        32'h200);
    tbl[1]  = mk(1, 0, 1, 0, 0, 32'h3C,       32'h1001,     32'h0,        32'h0,        32'h0,        1, 32'd3,         32'h0,         32'h1000);
    tbl[2]  = mk(1, 0, 0, 0, 1, 32'h40,       32'h201,      32'h0,        32'h8,        32'h80,       1, 32'h8000_0007, 32'h80,        irq_tgt);
    tbl[3]  = mk(1, 0, 0, 0, 1, 32'h40,       32'h200,      32'h0,        32'h0,        32'h80,       0, 32'h0,         32'h0,         32'h0);
    tbl[4]  = mk(1, 0, 0, 0, 1, 32'h40,       32'h200,      32'h0,        32'h8,        32'h0,        0, 32'h0,         32'h0,         32'h0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 32'h80,       32'h200,      32'h104,      32'h80,       32'h0,        2, 32'h0,         32'h88,        32'h104);
    tbl[6]  = mk(1, 1, 0, 0, 1, 32'h44,       32'h200,      32'h0,        32'h8,        32'h80,       1, 32'd11,        32'h80,        32'h200);
    tbl[7]  = mk(0, 1, 0, 0, 0, 32'h48,       32'h200,      32'h0,        32'h8,        32'h0,        0, 32'h0,         32'h0,         32'h0);
    tbl[8]  = mk(1, 0, 0, 1, 0, 32'h4C,       32'h200,      32'hABC0,     32'hFFFF_FF77, 32'h0,       2, 32'h0,         32'hFFFF_FFF7, 32'hABC0);
    tbl[9]  = mk(1, 1, 0, 1, 0, 32'h50,       32'h301,      32'h0,        32'h88,       32'h0,        1, 32'd11,        32'h80,        32'h300);
    tbl[10] = mk(0, 0, 0, 0, 1, 32'h54,       32'h200,      32'h0,        32'h8,        32'h80,       0, 32'h0,         32'h0,         32'h0);
    tbl[11] = mk(1, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'h0,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd3,      32'hFFFF_FFF7, 32'hFFFF_FFFC);
    zero_v = '0;

    rst_n = 1'b0;
    inst_valid_i = 0; inst_ecall_i = 0; inst_ebreak_i = 0; inst_mret_i = 0; irq_timer_i = 0;
    inst_addr_i = 0; mtvec_i = 0; mepc_i = 0; mstatus_i = 0; mie_i = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset", 0, zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset", 0, zero_v);

    // Table vectors, each followed by an idle cycle (stall must drop).
    for (int i = 0; i < 12; i++) begin
      do_event(tbl[i], $sformatf("tbl%0d", i));
      idle_check($sformatf("tbl%0d_idle", i));
    end

    // Priority and re-take: irq held high through ecall, masked while MIE=0,
    // mret, then taken in the cycle right after the mret jump.
    irq_timer_i = 1'b1;
    do_event(mk(1, 1, 0, 0, 1, 32'h60, 32'h200, 32'h0, 32'h8, 32'h80, 1, 32'd11, 32'h80, 32'h200), "prio_ecall");
    do_event(mk(1, 0, 0, 0, 1, 32'h200, 32'h200, 32'h60, 32'h80, 32'h80, 0, 0, 0, 0), "prio_masked");
    do_event(mk(1, 0, 0, 1, 1, 32'h204, 32'h200, 32'h60, 32'h80, 32'h80, 2, 0, 32'h88, 32'h60), "prio_mret");
    do_event(mk(1, 0, 0, 0, 1, 32'h60, 32'h200, 32'h60, 32'h88, 32'h80, 1, 32'h8000_0007, 32'h80, 32'h200), "prio_irq_b2b");
    irq_timer_i = 1'b0;
    idle_check("prio_idle");

    // Reset while in W_MSTATUS.
    @(negedge clk);
    inst_valid_i = 1; inst_ecall_i = 1; inst_addr_i = 32'h500; mtvec_i = 32'h600; mstatus_i = 32'h8;
    #1 chk("rst_mid_acc", 0, '{we:1'b0, waddr:32'h0, wdata:32'h0, stall:1'b1, jump:1'b0, jaddr:32'h0});
    @(negedge clk);
    inst_valid_i = 0; inst_ecall_i = 0;
    #1 chk("rst_mid_mepc", 1, '{we:1'b1, waddr:32'h341, wdata:32'h500, stall:1'b1, jump:1'b0, jaddr:32'h0});
    @(negedge clk);
    #1 chk("rst_mid_mstatus", 2, '{we:1'b1, waddr:32'h300, wdata:32'h80, stall:1'b1, jump:1'b0, jaddr:32'h0});
    rst_n = 1'b0;
    #1 chk("rst_mid_assert", 2, zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("rst_mid_after", i, zero_v);
    end

    // Randomized events against the model.
    for (int i = 0; i < 60; i++) begin
      r.valid   = ($urandom_range(0, 7) != 0);
      r.ecall   = ($urandom_range(0, 3) == 0);
      r.ebreak  = ($urandom_range(0, 3) == 0);
      r.mret    = ($urandom_range(0, 3) == 0);
      r.irq     = ($urandom_range(0, 1) == 0);
      r.pc      = $urandom & ~32'h3;
      r.mtvec   = $urandom;
      r.mtvec[1:0] = 2'($urandom_range(0, 1));
      r.mepc    = $urandom;
      r.mstatus = $urandom;
      r.mie     = $urandom;
      r.kind = 0; r.cause = 0; r.mst_w = 0; r.target = 0;
      e = predict(r);
      do_event(e, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d_idle", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
